uart_tx_serializer: RTL and testbench

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_tx_serializer.sv | 151 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: accepts one payload per frame and shifts out
// start, data (LSB first), optional parity and stop bits, one bit per baud_tick.
module uart_tx_serializer #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CNT_W = $clog2(DATA_BITS) + 1;
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);
  localparam logic ODD_BIT = (PARITY_ODD != 0);
  localparam logic HAS_PARITY = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    done_d   = 1'b0;

    case (state_q)
      // Ticks are deliberately ignored here; SYNC realigns to the next tick.
      IDLE: begin
        tx_d = 1'b1;
        if (tx_valid) begin
          shift_d  = tx_data;
          parity_d = (^tx_data) ^ ODD_BIT;
          cnt_d    = '0;
          state_d  = SYNC;
        end
      end

      SYNC: begin
        tx_d = 1'b1;
        if (baud_tick) begin
          tx_d    = 1'b0;
          cnt_d   = '0;
          state_d = START;
        end
      end

      START: begin
        if (baud_tick) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = '0;
          state_d = DATA;
        end
      end

      DATA: begin
        if (baud_tick) begin
          if (cnt_q == LAST_DATA) begin
            cnt_d = '0;
            if (HAS_PARITY) begin
              tx_d    = parity_q;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            cnt_d   = cnt_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end

      PARITY: begin
        if (baud_tick) begin
          tx_d    = 1'b1;
          cnt_d   = '0;
          state_d = STOP;
        end
      end

      STOP: begin
        tx_d = 1'b1;
        if (baud_tick) begin
          if (cnt_q == LAST_STOP) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign tx       = tx_q;
  assign tx_done  = done_q;
  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench: three serializer configurations share stimulus; frames
// are checked bit by bit at each baud tick against a frame-level model.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic [7:0] tx_data;
  logic [2:0] valid_v;
  logic [2:0] ready_v, tx_v, busy_v, done_v;

  always #5 clk = ~clk;

  // 0: 8N1, 1: 8E2, 2: 8O1
  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(valid_v[0]),
    .tx_ready(ready_v[0]), .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));
  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(valid_v[1]),
    .tx_ready(ready_v[1]), .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));
  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(valid_v[2]),
    .tx_ready(ready_v[2]), .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));

  int   checks = 0;
  int   failures = 0;
  int   gap_cnt = 15;
  bit   rand_gap = 0;
  bit   keep_valid = 0;
  logic last_tick;
  logic [2:0] pre_ready;
  int   sync_cycles, start_cycles;

  typedef struct {
    int          sel;
    logic [7:0]  data;
    logic [15:0] exp_bits;
    int          exp_len;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Frame as a bit list in transmission order (index 0 = start bit).
  function automatic void model_frame(input int sel, input logic [7:0] d,
                                      output logic [15:0] bits, output int len);
    int   stops;
    logic par;
    bits = '0;
    len  = 1;
    for (int i = 0; i < 8; i++) begin
      bits[4'(len)] = d[i];
      len++;
    end
    if (sel != 0) begin
      par = ^d;
      if (sel == 2) par = ~par;
      bits[4'(len)] = par;
      len++;
    end
    stops = (sel == 1) ? 2 : 1;
    for (int i = 0; i < stops; i++) begin
      bits[4'(len)] = 1'b1;
      len++;
    end
  endfunction

  task automatic cycle();
    baud_tick = (gap_cnt == 0);
    pre_ready = ready_v;
    @(posedge clk);
    #1;
    last_tick = baud_tick;
    if (gap_cnt == 0) gap_cnt = rand_gap ? int'($urandom_range(0, 10)) : 15;
    else gap_cnt--;
  endtask

  task automatic offer(input int sel, input logic [7:0] d, output int waited);
    tx_data = d;
    valid_v[sel] = 1'b1;
    waited = 0;
    do begin
      cycle();
      waited++;
    end while (!pre_ready[sel] && waited < 400);
    if (!keep_valid) valid_v[sel] = 1'b0;
    check("accept", {31'd0, pre_ready[sel]}, 32'd1);
  endtask

  task automatic collect(input int sel, input logic [15:0] exp_bits, input int exp_len,
                         input string name, input int chg_bit);
    logic [15:0] got;
    logic hold_val;
    bit   hold_err, stat_err, tmo;
    int   n;
    got = '0; hold_val = 1'b1; hold_err = 0; stat_err = 0; tmo = 0;
    for (int b = 0; b <= exp_len; b++) begin
      if (b == chg_bit) tx_data = 8'hFF;
      n = 0;
      do begin
        cycle();
        n++;
        if (!last_tick) begin
          if (tx_v[sel] !== hold_val) hold_err = 1;
          if (ready_v[sel] !== 1'b0 || busy_v[sel] !== 1'b1 || done_v[sel] !== 1'b0) stat_err = 1;
        end
      end while (!last_tick && n < 64);
      if (!last_tick) tmo = 1;
      if (b == 0) sync_cycles = n;
      if (b == 1) start_cycles = n;
      if (b < exp_len) begin
        got[4'(b)] = tx_v[sel];
        hold_val = tx_v[sel];
        if (ready_v[sel] !== 1'b0 || busy_v[sel] !== 1'b1 || done_v[sel] !== 1'b0) stat_err = 1;
      end
    end
    check({name, "_frame"}, {16'd0, got}, {16'd0, exp_bits});
    check({name, "_hold"}, {31'd0, hold_err}, 32'd0);
    check({name, "_status"}, {31'd0, stat_err}, 32'd0);
    check({name, "_timeout"}, {31'd0, tmo}, 32'd0);
    check({name, "_done"}, {31'd0, done_v[sel]}, 32'd1);
    check({name, "_ready_end"}, {29'd0, ready_v[sel], busy_v[sel], tx_v[sel]}, 32'b101);
  endtask

  task automatic done_width(input int sel, input string name);
    cycle();
    check({name, "_done_width"}, {31'd0, done_v[sel]}, 32'd0);
  endtask

  initial begin
    logic [15:0] bits;
    int          len, w, ticks, n, sel;
    logic [7:0]  d;
    bit          bad;

    vecs[0] = '{0, 8'hA5, 16'h034A, 10};
    vecs[1] = '{1, 8'h07, 16'h0E0E, 12};
    vecs[2] = '{2, 8'h07, 16'h040E, 11};
    vecs[3] = '{0, 8'h00, 16'h0200, 10};
    vecs[4] = '{1, 8'hFF, 16'h0DFE, 12};

    rst = 1'b0; baud_tick = 1'b0; tx_data = 8'h00; valid_v = 3'b000;
    #1;
    repeat (2) cycle();
    for (int s = 0; s < 3; s++)
      check($sformatf("reset_state%0d", s),
            {28'd0, tx_v[s], ready_v[s], busy_v[s], done_v[s]}, 32'b1100);
    rst = 1'b1;
    cycle();
    check("resume_ready", {29'd0, ready_v}, 32'b111);

    // Table-driven frames
    for (int i = 0; i < 5; i++) begin
      offer(vecs[i].sel, vecs[i].data, w);
      collect(vecs[i].sel, vecs[i].exp_bits, vecs[i].exp_len, $sformatf("vec%0d", i), -1);
      done_width(vecs[i].sel, $sformatf("vec%0d", i));
      $display("vec%0d sel=%0d data=0x%0h done", i, vecs[i].sel, vecs[i].data);
    end

    // Payload changes while busy must not leak into the frame
    keep_valid = 1;
    offer(0, 8'h3C, w);
    model_frame(0, 8'h3C, bits, len);
    collect(0, bits, len, "busy", 4);
    valid_v[0] = 1'b0;
    keep_valid = 0;
    done_width(0, "busy");
    $display("busy protection frame 0x3C done");

    // Acceptance on the same edge as a tick
    n = 0;
    while (gap_cnt != 0 && n < 32) begin
      cycle();
      n++;
    end
    offer(0, 8'hC3, w);
    model_frame(0, 8'hC3, bits, len);
    collect(0, bits, len, "align", -1);
    check("align_sync_cycles", sync_cycles, 16);
    check("align_start_cycles", start_cycles, 16);
    done_width(0, "align");
    $display("tick alignment frame 0xC3 done");

    // Reset during data bit 3
    offer(0, 8'h96, w);
    ticks = 0; n = 0;
    while (ticks < 5 && n < 200) begin
      cycle();
      n++;
      if (last_tick) ticks++;
    end
    repeat (3) cycle();
    check("rst_pre_bit3", {31'd0, tx_v[0]}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_async", {28'd0, tx_v[0], ready_v[0], busy_v[0], done_v[0]}, 32'b1100);
    bad = 0;
    repeat (4) begin
      cycle();
      if (done_v[0] !== 1'b0 || tx_v[0] !== 1'b1) bad = 1;
    end
    check("rst_hold_quiet", {31'd0, bad}, 32'd0);
    rst = 1'b1;
    cycle();
    check("rst_resume", {30'd0, ready_v[0], busy_v[0]}, 32'b10);
    offer(0, 8'h55, w);
    collect(0, 16'h02AA, 10, "after_rst", -1);
    done_width(0, "after_rst");
    $display("reset mid-frame then 0x55 done");

    // Back-to-back frames
    offer(0, 8'h01, w);
    model_frame(0, 8'h01, bits, len);
    collect(0, bits, len, "b2b_first", -1);
    offer(0, 8'h80, w);
    check("b2b_accept_wait", w, 1);
    check("b2b_done_width", {31'd0, done_v[0]}, 32'd0);
    model_frame(0, 8'h80, bits, len);
    collect(0, bits, len, "b2b_second", -1);
    check("b2b_sync_gap", {31'd0, sync_cycles <= 16}, 32'd1);
    done_width(0, "b2b_second");
    $display("back-to-back 0x01,0x80 done");

    // Randomized frames with irregular tick spacing
    rand_gap = 1;
    for (int i = 0; i < 24; i++) begin
      sel = int'($urandom_range(0, 2));
      d = 8'($urandom);
      model_frame(sel, d, bits, len);
      offer(sel, d, w);
      collect(sel, bits, len, $sformatf("rand%0d", i), -1);
      done_width(sel, $sformatf("rand%0d", i));
      $display("rand%0d sel=%0d data=0x%0h frame=0x%0h len=%0d", i, sel, d, bits, len);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
